// File: rtl/led_cmd_scheduler_if.sv
// Command-source handshake bundle for led_cmd_scheduler: two requesters, each
// with valid/op_code in and a combinational ready back.
interface led_cmd_scheduler_if;
  // valid/ready: a command transfers on a rising clock edge where srcN_valid
  // and srcN_ready are both high; the requester holds srcN_op stable while
  // srcN_valid is high, and ready never depends on the requester's op.
  logic       src0_valid;
  logic [3:0] src0_op;
  logic       src0_ready;
  logic       src1_valid;
  logic [3:0] src1_op;
  logic       src1_ready;

  modport master (
    output src0_valid, src0_op, src1_valid, src1_op,
    input  src0_ready, src1_ready
  );

  modport slave (
    input  src0_valid, src0_op, src1_valid, src1_op,
    output src0_ready, src1_ready
  );
endinterface

// File: rtl/led_cmd_scheduler.sv
// Round-robin command arbiter + FIFO + hold/gap issue sequencer for the LED
// datapath op_code. Optional drop counter: define LED_SCHED_DROP_CNT_EN.
module led_cmd_scheduler #(
  parameter int DEPTH       = 4,
  parameter int HOLD_CYCLES = 10,
  parameter int GAP_CYCLES  = 2,
  localparam int LW         = $clog2(DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  led_cmd_scheduler_if.slave   src_if,
  output logic [3:0]           op_code,
  output logic                 busy,
  output logic                 power_on,
  output logic [LW-1:0]        fifo_level,
  output logic [1:0]           dbg_state
`ifdef LED_SCHED_DROP_CNT_EN
  ,
  output logic [7:0]           drop_count,
  output logic                 drop_pulse
`endif
);

  localparam int AW   = $clog2(DEPTH);
  localparam int MAXC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int CW   = $clog2(MAXC + 1);
  localparam logic [CW-1:0] HOLD_LOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'(GAP_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_e;

  // FIFO storage and bookkeeping
  logic [3:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] count_q, count_d;
  logic          full, empty;
  logic [3:0]    head;

  // arbitration
  logic [1:0]    grant;
  logic          prefer1_q;
  logic          xfer;
  logic [3:0]    push_op;
  logic          push, pop;

  // issue sequencer
  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    op_q, op_d;
  logic          pwr_q, pwr_d;

  assign full  = (count_q == LW'(DEPTH));
  assign empty = (count_q == '0);
  assign head  = mem_q[rd_ptr_q];

  // Grant is held low during reset so no requester sees a phantom accept.
  always_comb begin
    grant = 2'b00;
    if (rst_n && !full) begin
      if (src_if.src0_valid && src_if.src1_valid) grant = prefer1_q ? 2'b10 : 2'b01;
      else if (src_if.src0_valid)                 grant = 2'b01;
      else if (src_if.src1_valid)                 grant = 2'b10;
    end
  end

  assign src_if.src0_ready = grant[0];
  assign src_if.src1_ready = grant[1];
  assign xfer    = |grant;
  assign push_op = grant[1] ? src_if.src1_op : src_if.src0_op;
  assign push    = xfer && (push_op != 4'd0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= push_op;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      prefer1_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
      if (xfer) prefer1_q <= grant[0];
    end
  end

  // Sequencer state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= 4'd0;
      pwr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      pwr_q   <= pwr_d;
    end
  end

`ifdef LED_SCHED_DROP_CNT_EN
  logic discard;
`endif

  // Sequencer next state; pre-power-on commands other than 1 are popped and dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    pwr_d   = pwr_q;
    pop     = 1'b0;
`ifdef LED_SCHED_DROP_CNT_EN
    discard = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (!empty) begin
          pop = 1'b1;
          if (head == 4'd1) begin
            op_d    = 4'd1;
            pwr_d   = 1'b1;
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end else if (pwr_q) begin
            op_d    = head;
            state_d = HOLD;
            cnt_d   = HOLD_LOAD;
          end else begin
`ifdef LED_SCHED_DROP_CNT_EN
            discard = 1'b1;
`endif
          end
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          op_d    = 4'd0;
          state_d = GAP;
          cnt_d   = GAP_LOAD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: begin
        state_d = IDLE;
        op_d    = 4'd0;
      end
    endcase
  end

  // Sequencer outputs
  always_comb begin
    op_code    = op_q;
    power_on   = pwr_q;
    fifo_level = count_q;
    busy       = !empty || (state_q != IDLE);
    dbg_state  = state_q;
  end

`ifdef LED_SCHED_DROP_CNT_EN
  logic [7:0] drop_cnt_q;
  logic       drop_pulse_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      drop_cnt_q   <= 8'd0;
      drop_pulse_q <= 1'b0;
    end else begin
      drop_pulse_q <= discard;
      if (discard && drop_cnt_q != 8'hFF) drop_cnt_q <= drop_cnt_q + 8'd1;
    end
  end

  assign drop_count = drop_cnt_q;
  assign drop_pulse = drop_pulse_q;
`endif

endmodule

// File: tb/tb_led_cmd_scheduler.sv
// Directed bench for led_cmd_scheduler: scoreboard of expected issued op_codes,
// monitor checking order, hold length and gap length on every issue.
module tb_led_cmd_scheduler;
  localparam int DEPTH = 4;
  localparam int HOLD  = 10;
  localparam int GAP   = 2;
  localparam int LW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [3:0]    op_code;
  logic          busy, power_on;
  logic [LW-1:0] fifo_level;
  logic [1:0]    dbg_state;
`ifdef LED_SCHED_DROP_CNT_EN
  logic [7:0]    drop_count;
  logic          drop_pulse;
`endif

  led_cmd_scheduler_if sif ();

  led_cmd_scheduler #(.DEPTH(DEPTH), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .src_if     (sif),
    .op_code    (op_code),
    .busy       (busy),
    .power_on   (power_on),
    .fifo_level (fifo_level),
    .dbg_state  (dbg_state)
`ifdef LED_SCHED_DROP_CNT_EN
    ,
    .drop_count (drop_count),
    .drop_pulse (drop_pulse)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  int tests_run    = 0;
  int tests_failed = 0;

  logic [3:0] exp_q [$];
  bit         model_pwr = 0;
  int         exp_drops = 0;
  int         pulses_seen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // scoreboard model of what a transferred command should become
  task automatic model_accept(input logic [3:0] op);
    if (op != 4'd0) begin
      if (op == 4'd1) model_pwr = 1;
      if (op == 4'd1 || model_pwr) exp_q.push_back(op);
      else exp_drops++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    model_pwr   = 0;
    exp_drops   = 0;
    pulses_seen = 0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
  endtask

  // driver: offer one command from src (0/1), wait for the handshake
  task automatic send(input int src, input logic [3:0] op);
    bit got = 0;
    @(negedge clk);
    if (src == 0) begin sif.src0_valid = 1'b1; sif.src0_op = op; end
    else          begin sif.src1_valid = 1'b1; sif.src1_op = op; end
    for (int n = 0; n < 300 && !got; n++) begin
      #2;
      if ((src == 0) ? sif.src0_ready : sif.src1_ready) got = 1;
      else @(negedge clk);
    end
    if (got) begin
      @(posedge clk);
      #1;
      model_accept(op);
    end
    sif.src0_valid = 1'b0;
    sif.src1_valid = 1'b0;
    check("send_accepted", got, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while ((busy || op_code != 4'd0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    check("idle_reached", n < 500, 1);
  endtask

  task automatic wait_op(input logic [3:0] v);
    int n = 0;
    while (op_code != v && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("op_seen", op_code, v);
  endtask

  // monitor: every issued op_code is compared with the scoreboard head
  logic [3:0] prev_op = 4'd0;
  int         run = 0;
  bit         seen_op = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_op = 4'd0;
      run     = 0;
      seen_op = 0;
    end else begin
      if (op_code != prev_op) begin
        if (prev_op == 4'd0) begin
          if (seen_op) check("gap_min", run >= GAP, 1);
          if (exp_q.size() == 0) check("unexpected_issue", op_code, 0);
          else check("issue_order", op_code, exp_q.pop_front());
          check("power_with_issue", power_on, 1);
          check("busy_with_issue", busy, 1);
        end else if (op_code == 4'd0) begin
          check("hold_len", run, HOLD);
          seen_op = 1;
        end else begin
          check("clean_edge", op_code, 0);
        end
        run = 1;
      end else begin
        run++;
      end
      prev_op = op_code;
    end
`ifdef LED_SCHED_DROP_CNT_EN
    if (rst_n && drop_pulse) pulses_seen++;
`endif
  end

  initial begin
    int n;
    int guard;
    sif.src0_valid = 1'b1;
    sif.src0_op    = 4'd5;
    sif.src1_valid = 1'b1;
    sif.src1_op    = 4'd6;

    // reset state, with both requesters pushing
    #12;
    check("rst_op_code", op_code, 0);
    check("rst_busy", busy, 0);
    check("rst_power_on", power_on, 0);
    check("rst_fifo_level", fifo_level, 0);
    check("rst_ready", {sif.src1_ready, sif.src0_ready}, 2'b00);
    check("rst_state", dbg_state, 2'd0);
    sif.src0_valid = 1'b0;
    sif.src1_valid = 1'b0;
    sif.src0_op    = 4'd0;
    sif.src1_op    = 4'd0;
    do_reset();

    // power on then mode op from src1
    send(1, 4'd1);
    send(1, 4'd6);
    wait_idle();
    check("t1_power_on", power_on, 1);
    check("t1_queue_drained", exp_q.size(), 0);

    // pre-power-on commands are discarded
    do_reset();
    send(0, 4'd4);
    send(0, 4'd8);
    send(0, 4'd1);
    wait_idle();
    check("t2_power_on", power_on, 1);
    check("t2_queue_drained", exp_q.size(), 0);
`ifdef LED_SCHED_DROP_CNT_EN
    check("t2_drop_count", drop_count, exp_drops);
    check("t2_drop_pulses", pulses_seen, exp_drops);
`endif

    // round robin with both requesters continuously valid
    do_reset();
    send(1, 4'd1);
    @(negedge clk);
    sif.src0_valid = 1'b1; sif.src0_op = 4'd2;
    sif.src1_valid = 1'b1; sif.src1_op = 4'd3;
    n = 0;
    guard = 0;
    while (n < 4 && guard < 300) begin
      #2;
      if (sif.src0_ready || sif.src1_ready) begin
        check("rr_order", {sif.src1_ready, sif.src0_ready}, (n % 2 == 0) ? 2'b01 : 2'b10);
        model_accept(sif.src0_ready ? 4'd2 : 4'd3);
        n++;
      end
      @(negedge clk);
      guard++;
    end
    sif.src0_valid = 1'b0;
    sif.src1_valid = 1'b0;
    check("rr_transfers", n, 4);
    wait_idle();
    check("t3_queue_drained", exp_q.size(), 0);

    // fill the FIFO while a HOLD is active
    send(0, 4'd7);
    wait_op(4'd7);
    send(0, 4'd2);
    send(1, 4'd3);
    send(0, 4'd4);
    send(1, 4'd5);
    @(negedge clk);
    check("fill_level", fifo_level, DEPTH);
    sif.src1_valid = 1'b1;
    sif.src1_op    = 4'd6;
    n = 0;
    while (n < 300) begin
      #2;
      if (sif.src1_ready) break;
      check("full_ready_low", {sif.src1_ready, sif.src0_ready}, 2'b00);
      check("full_level_held", fifo_level, DEPTH);
      @(negedge clk);
      n++;
    end
    check("fifth_accept_level", fifo_level, DEPTH - 1);
    @(posedge clk);
    #1;
    if (n < 300) model_accept(4'd6);
    sif.src1_valid = 1'b0;
    check("fifth_accepted", n < 300, 1);
    check("fifth_level_after", fifo_level, DEPTH);
    wait_idle();
    check("t4_queue_drained", exp_q.size(), 0);

    // op 0 completes the handshake but never reaches the FIFO
    send(0, 4'd0);
    check("op0_level", fifo_level, 0);
    repeat (5) @(negedge clk);
    check("op0_op_code", op_code, 0);
    check("op0_busy", busy, 0);

    // reset in the middle of a HOLD with two commands queued
    send(1, 4'd7);
    wait_op(4'd7);
    send(0, 4'd2);
    send(1, 4'd3);
    check("pre_rst_level", fifo_level, 2);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_op_code", op_code, 0);
    check("mid_rst_level", fifo_level, 0);
    check("mid_rst_power_on", power_on, 0);
    check("mid_rst_busy", busy, 0);
    exp_q.delete();
    model_pwr = 0;
    exp_drops = 0;
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_op_code", op_code, 0);
    check("post_rst_level", fifo_level, 0);
    check("post_rst_power_on", power_on, 0);
    check("final_queue_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // absolute time limit
  initial begin
    #400000;
    check("global_timeout", 0, 1);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $fatal(1, "FAIL global_timeout: simulation time limit reached");
  end

endmodule
